// File: rtl/result_pack_pkg.sv
// Constants shared with the compute engine: lane count, op codes, and the
// state/mode encodings used by the result_pack output stage.
package result_pack_pkg;

  localparam int BURST_LEN = 8;

  localparam logic [2:0] OP_CONV  = 3'd1;
  localparam logic [2:0] OP_MPOOL = 3'd2;
  localparam logic [2:0] OP_APOOL = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_NONE = 2'd0,
    MODE_CONV = 2'd1,
    MODE_POOL = 2'd2
  } mode_e;

  // Unknown op codes map to MODE_NONE: every result is dropped and flagged.
  function automatic mode_e op_mode(input logic [2:0] op);
    case (op)
      OP_CONV:            return MODE_CONV;
      OP_MPOOL, OP_APOOL: return MODE_POOL;
      default:            return MODE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/result_pack_line_buf_ram.sv
// Simple dual-port line buffer: per-lane 16-bit writes, 1-cycle registered
// read, optional clear of the row being read.
module line_buf_ram
  import result_pack_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int LANES = BURST_LEN,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic [LANES-1:0]      we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [15:0]           wdata_i,
  input  logic                  re_i,
  input  logic                  rclr_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [16*LANES-1:0]   rdata_o
);

  logic [16*LANES-1:0] mem_q [DEPTH];
  logic [16*LANES-1:0] rdata_q;

  // Lane writes are listed after the clear so a same-row write still lands.
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
      if (rclr_i) mem_q[raddr_i] <= '0;
    end
    for (int k = 0; k < LANES; k++) begin
      if (we_i[k]) mem_q[waddr_i][16*k +: 16] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/result_pack.sv
// Collects the engine's serial writeback into a line buffer and drains it
// position-major to the output DMA, one BURST_LEN-lane word per row.
module result_pack
  import result_pack_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [2:0]              op_type,
  input  logic [7:0]              o_side,
  input  logic [ADDR_W-1:0]       addr_base,
  input  logic                    output_en,
  input  logic [15:0]             output_data,
  input  logic                    gemm_finish,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [16*BURST_LEN-1:0] wr_data,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [BURST_LEN-1:0]    wr_strb,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [1:0]              dbg_state_o
);

  localparam int RAW = $clog2(DEPTH);
  localparam int PW  = RAW + 1;
  localparam int LW  = $clog2(BURST_LEN) + 1;
  localparam int DW  = 16 * BURST_LEN;

  state_e                state_q, state_d;
  mode_e                 mode_q;
  logic [7:0]            o_side_q;
  logic [ADDR_W-1:0]     base_q;
  logic [PW-1:0]         pos_q, pos_d, rows_q, rows_d, rd_row_q, rd_row_d;
  logic [LW-1:0]         lane_q, lane_d;
  logic [BURST_LEN-1:0]  mask_q, mask_d, ram_we;
  logic                  gf_q, ovf_q, ovf_d;
  logic                  infl_q, infl_d;
  logic [ADDR_W-1:0]     infl_addr_q, infl_addr_d;
  logic                  h_v_q, h_v_d, t_v_q, t_v_d;
  logic [DW-1:0]         h_data_q, h_data_d, t_data_q, t_data_d;
  logic [ADDR_W-1:0]     h_addr_q, h_addr_d, t_addr_q, t_addr_d;
  logic                  bad_wr, wr_ok, rise, re, pop;
  logic [DW-1:0]         ram_rdata, mask_wide;

  always_comb begin
    bad_wr = 1'b1;
    case (mode_q)
      MODE_CONV: bad_wr = (lane_q == LW'(BURST_LEN));
      MODE_POOL: bad_wr = (pos_q == PW'(DEPTH));
      default:   bad_wr = 1'b1;
    endcase
    wr_ok = output_en && (state_q == ST_FILL) && !bad_wr;
    for (int k = 0; k < BURST_LEN; k++) begin
      ram_we[k]             = wr_ok && (lane_q == LW'(k));
      mask_wide[16*k +: 16] = {16{mask_q[k]}};
    end
  end

  assign rise = gemm_finish && !gf_q;
  // Handshake: a beat moves on any cycle with wr_valid && wr_ready; while
  // stalled the head entry (and so wr_data/wr_addr/wr_strb) never changes.
  assign pop  = h_v_q && wr_ready;

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    lane_d      = lane_q;
    mask_d      = mask_q | ram_we;
    rows_d      = rows_q;
    rd_row_d    = rd_row_q;
    ovf_d       = ovf_q;
    re          = 1'b0;
    infl_d      = 1'b0;
    infl_addr_d = base_q + ADDR_W'(rd_row_q);
    h_v_d       = h_v_q;
    h_data_d    = h_data_q;
    h_addr_d    = h_addr_q;
    t_v_d       = t_v_q;
    t_data_d    = t_data_q;
    t_addr_d    = t_addr_q;

    if (wr_ok) begin
      if (mode_q == MODE_CONV) begin
        if (pos_q + PW'(1) == PW'(o_side_q)) begin
          pos_d  = '0;
          lane_d = lane_q + LW'(1);
        end else begin
          pos_d = pos_q + PW'(1);
        end
      end else if (lane_q == LW'(BURST_LEN - 1)) begin
        lane_d = '0;
        pos_d  = pos_q + PW'(1);
      end else begin
        lane_d = lane_q + LW'(1);
      end
    end

    // Two-entry skid: pop first, then the read returning this cycle takes
    // the first free slot.
    if (pop) begin
      h_v_d    = t_v_q;
      h_data_d = t_data_q;
      h_addr_d = t_addr_q;
      t_v_d    = 1'b0;
    end
    if (infl_q) begin
      if (!h_v_d) begin
        h_v_d    = 1'b1;
        h_data_d = ram_rdata & mask_wide;
        h_addr_d = infl_addr_q;
      end else begin
        t_v_d    = 1'b1;
        t_data_d = ram_rdata & mask_wide;
        t_addr_d = infl_addr_q;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FILL;
          pos_d   = '0;
          lane_d  = '0;
          mask_d  = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_FILL: begin
        if (rise) begin
          state_d  = ST_DRAIN;
          rd_row_d = '0;
          case (mode_q)
            MODE_CONV: rows_d = PW'(o_side_q);
            MODE_POOL: rows_d = pos_d;
            default:   rows_d = '0;
          endcase
        end
      end
      ST_DRAIN: begin
        // Only issue a read if the skid can hold it even with no pop next cycle.
        if (rd_row_q != rows_q && !t_v_d) begin
          re       = 1'b1;
          infl_d   = 1'b1;
          rd_row_d = rd_row_q + PW'(1);
        end else if (rd_row_q == rows_q && !infl_q && !h_v_d && !t_v_d) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (output_en && !wr_ok) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_NONE;
      o_side_q    <= '0;
      base_q      <= '0;
      pos_q       <= '0;
      lane_q      <= '0;
      mask_q      <= '0;
      rows_q      <= '0;
      rd_row_q    <= '0;
      gf_q        <= 1'b0;
      ovf_q       <= 1'b0;
      infl_q      <= 1'b0;
      infl_addr_q <= '0;
      h_v_q       <= 1'b0;
      h_data_q    <= '0;
      h_addr_q    <= '0;
      t_v_q       <= 1'b0;
      t_data_q    <= '0;
      t_addr_q    <= '0;
    end else begin
      if (state_q == ST_IDLE && start) begin
        mode_q   <= op_mode(op_type);
        o_side_q <= o_side;
        base_q   <= addr_base;
      end
      state_q     <= state_d;
      pos_q       <= pos_d;
      lane_q      <= lane_d;
      mask_q      <= mask_d;
      rows_q      <= rows_d;
      rd_row_q    <= rd_row_d;
      gf_q        <= gemm_finish;
      ovf_q       <= ovf_d;
      infl_q      <= infl_d;
      infl_addr_q <= infl_addr_d;
      h_v_q       <= h_v_d;
      h_data_q    <= h_data_d;
      h_addr_q    <= h_addr_d;
      t_v_q       <= t_v_d;
      t_data_q    <= t_data_d;
      t_addr_q    <= t_addr_d;
    end
  end

  line_buf_ram #(
    .DEPTH (DEPTH),
    .LANES (BURST_LEN),
    .AW    (RAW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (pos_q[RAW-1:0]),
    .wdata_i (output_data),
    .re_i    (re),
    .rclr_i  (1'b1),
    .raddr_i (rd_row_q[RAW-1:0]),
    .rdata_o (ram_rdata)
  );

  assign wr_valid    = h_v_q;
  assign wr_data     = h_data_q;
  assign wr_addr     = h_addr_q;
  assign wr_strb     = h_v_q ? mask_q : '0;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign overflow    = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_result_pack.sv
// Bench for result_pack: table of runs with a scoreboard queue of expected
// DMA beats, plus hand-written error, pre-high finish and mid-drain reset.
module tb_result_pack;
  import result_pack_pkg::*;

  localparam int AW = 10;
  localparam int DW = 16 * BURST_LEN;
  localparam int EW = DW + AW + BURST_LEN;

  logic                 clk, rst, start, output_en, gemm_finish, wr_ready;
  logic [2:0]           op_type;
  logic [7:0]           o_side;
  logic [AW-1:0]        addr_base;
  logic [15:0]          output_data;
  logic                 wr_valid, busy, done, overflow;
  logic [DW-1:0]        wr_data;
  logic [AW-1:0]        wr_addr;
  logic [BURST_LEN-1:0] wr_strb;
  logic [1:0]           dbg_state;

  result_pack #(.ADDR_W(AW), .DEPTH(256)) dut (
    .clk(clk), .rst(rst), .start(start), .op_type(op_type), .o_side(o_side),
    .addr_base(addr_base), .output_en(output_en), .output_data(output_data),
    .gemm_finish(gemm_finish), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_addr(wr_addr), .wr_strb(wr_strb), .busy(busy),
    .done(done), .overflow(overflow), .dbg_state_o(dbg_state)
  );

  typedef struct {
    logic [2:0]    op;
    int            o_side;
    logic [AW-1:0] base;
    int            n;
    int            extra;
    int            rmode;
    int            vmode;
    bit            gf_pre;
    int            exp_beats;
    logic [7:0]    exp_strb;
  } case_t;

  case_t          cases [8];
  logic [EW-1:0]  exp_q [$];
  int             checks = 0;
  int             failures = 0;
  int             beats_seen = 0;
  int             ready_mode = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ready driver
  initial begin
    int rcnt;
    rcnt = 0;
    wr_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rcnt++;
      case (ready_mode)
        0:       wr_ready = 1'b1;
        1:       wr_ready = (rcnt % 3 == 0);
        default: wr_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // scoreboard monitor
  initial begin
    logic          prev_stall;
    logic [EW-1:0] prev, e;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          check("stall_hold", {wr_valid, wr_data, wr_addr, wr_strb}, {1'b1, prev});
        if (wr_valid && wr_ready) begin
          beats_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL beat_unexpected: got %0h want none", {wr_data, wr_addr, wr_strb});
          end else begin
            e = exp_q.pop_front();
            check("beat", {wr_data, wr_addr, wr_strb}, e);
          end
        end
        prev_stall = wr_valid && !wr_ready;
        prev = {wr_data, wr_addr, wr_strb};
      end
    end
  end

  // driver: start, stream results, model expectations, raise gemm_finish
  task automatic load_case(input case_t c);
    logic [15:0]   row_m [256][BURST_LEN];
    logic [15:0]   v;
    logic [DW-1:0] d;
    int            rows, total;
    bit            conv;
    conv = (c.op == OP_CONV);
    beats_seen = 0;
    exp_q.delete();
    for (int r = 0; r < 256; r++)
      for (int l = 0; l < BURST_LEN; l++) row_m[r][l] = 16'h0;
    if (c.gf_pre) gemm_finish = 1'b1;
    op_type = c.op;
    o_side = 8'(c.o_side);
    addr_base = c.base;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1'b1);
    check("start_ovf_clear", overflow, 1'b0);
    check("start_state", dbg_state, ST_FILL);

    total = c.n + c.extra;
    for (int i = 0; i < total; i++) begin
      if (i >= c.n) v = 16'hBEEF;
      else if (c.vmode != 0) v = 16'($urandom_range(0, 65535));
      else if (conv) v = 16'((i / c.o_side) * 16 + (i % c.o_side));
      else v = 16'(i);
      if (i < c.n) begin
        if (conv) begin
          if (i / c.o_side < BURST_LEN) row_m[i % c.o_side][i / c.o_side] = v;
        end else begin
          row_m[i / BURST_LEN][i % BURST_LEN] = v;
        end
      end
      output_en = 1'b1;
      output_data = v;
      if (!c.gf_pre && i == total - 1) gemm_finish = 1'b1;
      tick();
      output_en = 1'b0;
      if (i != total - 1 && $urandom_range(0, 3) == 0) tick();
    end

    rows = conv ? c.o_side : c.n / BURST_LEN;
    for (int r = 0; r < rows; r++) begin
      d = '0;
      for (int l = 0; l < BURST_LEN; l++)
        if (c.exp_strb[l]) d[16*l +: 16] = row_m[r][l];
      exp_q.push_back({d, AW'(c.base + AW'(r)), c.exp_strb});
    end

    if (c.gf_pre) begin
      tick();
      check("gf_pre_no_drain", dbg_state, ST_FILL);
      gemm_finish = 1'b0;
      tick();
      gemm_finish = 1'b1;
      tick();
    end else if (total == 0) begin
      gemm_finish = 1'b1;
      tick();
    end
    gemm_finish = 1'b0;
  endtask

  task automatic wait_first_valid(output int lat);
    lat = 0;
    while (!wr_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("first_valid_latency", lat, 2);
  endtask

  task automatic finish_case(input case_t c);
    int lat, cyc;
    if (c.exp_beats > 0) wait_first_valid(lat);
    cyc = 0;
    while (!done && cyc < 500) begin
      tick();
      cyc++;
    end
    check("done_seen", done, 1'b1);
    check("done_valid_low", wr_valid, 1'b0);
    check("done_busy", busy, 1'b1);
    check("beat_count", beats_seen, c.exp_beats);
    check("queue_empty", exp_q.size(), 0);
    check("overflow_flag", overflow, c.extra > 0);
    tick();
    check("done_pulse_end", done, 1'b0);
    check("idle_busy", busy, 1'b0);
  endtask

  initial begin
    int  lat;
    bit  saw_done;
    case_t c_rst;
    cases[0] = '{OP_CONV,  3, 10'h010, 24, 0, 0, 0, 1'b0, 3, 8'hFF};
    cases[1] = '{OP_CONV,  2, 10'h020,  8, 0, 0, 0, 1'b0, 2, 8'h0F};
    cases[2] = '{OP_MPOOL, 2, 10'h030, 16, 0, 0, 0, 1'b1, 2, 8'hFF};
    cases[3] = '{OP_CONV,  4, 10'h100, 32, 0, 1, 1, 1'b0, 4, 8'hFF};
    cases[4] = '{OP_CONV,  2, 10'h040, 16, 1, 2, 1, 1'b0, 2, 8'hFF};
    cases[5] = '{OP_APOOL, 4, 10'h3FF, 16, 0, 2, 1, 1'b0, 2, 8'hFF};
    cases[6] = '{OP_MPOOL, 4, 10'h050,  0, 0, 0, 1, 1'b0, 0, 8'h00};
    cases[7] = '{OP_CONV,  1, 10'h077,  8, 0, 0, 1, 1'b0, 1, 8'hFF};
    c_rst    = '{OP_CONV,  4, 10'h200, 32, 0, 0, 1, 1'b0, 4, 8'hFF};

    rst = 1'b1;
    start = 1'b0;
    op_type = '0;
    o_side = '0;
    addr_base = '0;
    output_en = 1'b0;
    output_data = '0;
    gemm_finish = 1'b0;
    repeat (3) tick();
    check("rst_wr_valid", wr_valid, 1'b0);
    check("rst_wr_data", wr_data, '0);
    check("rst_wr_addr", wr_addr, '0);
    check("rst_wr_strb", wr_strb, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    tick();

    output_en = 1'b1;
    output_data = 16'h1234;
    tick();
    output_en = 1'b0;
    check("idle_write_ovf", overflow, 1'b1);
    check("idle_write_busy", busy, 1'b0);

    for (int i = 0; i < 7; i++) begin
      ready_mode = cases[i].rmode;
      load_case(cases[i]);
      finish_case(cases[i]);
      repeat (2) tick();
    end

    ready_mode = 0;
    load_case(c_rst);
    wait_first_valid(lat);
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_valid", wr_valid, 1'b0);
    check("mid_rst_state", dbg_state, ST_IDLE);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_beats", beats_seen, 1);
    rst = 1'b0;
    exp_q.delete();
    saw_done = 1'b0;
    repeat (4) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    check("mid_rst_no_done", saw_done, 1'b0);

    load_case(cases[7]);
    finish_case(cases[7]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
